rr_reg_bank_arbiter: RTL and testbench
======================================

// Module: rr_reg_bank_arbiter
// PURPOSE
//  Shares one bank of DEPTH enable-gated D registers between NREQ write requesters.
//  Each cycle a round-robin arbiter picks one winner and drives that register's enable.
//  The winner's data is loaded on the same clock edge, and a one-cycle grant is returned.
//  Sits between requester logic and the register bank; asynchronous read port for consumers.
// PARAMETERS
//  NREQ    4  number of write requesters (>=2)
//  DEPTH   8  registers in bank
//  ADDR_W  3  address width, = clog2(DEPTH)
//  WIDTH   8  register data width
// PORTS
//  clk      in   1             rising-edge clock
//  rst      in   1             asynchronous reset, active-high
//  hold     in   1             1 = freeze: no grants, bank holds, rr_ptr holds
//  req      in   NREQ          per-requester write request, level
//  wr_addr  in   NREQ*ADDR_W   requester i address at [i*ADDR_W +: ADDR_W]
//  wr_data  in   NREQ*WIDTH    requester i data at [i*WIDTH +: WIDTH]
//  lock     in   NREQ          burst lock (used only with ARB_LOCK_EN)
//  gnt      out  NREQ          registered one-hot grant, 1 cycle wide
//  busy     out  1             registered; 1 if any request lost arbitration this edge
//  rd_addr  in   ADDR_W        read address
//  rd_data  out  WIDTH         combinational bank[rd_addr]
// BEHAVIOUR
//  - rst=1 (async): all bank entries, gnt, busy and rr_ptr are cleared to 0.
//  - eligible = req & ~gnt: a requester whose gnt is high this cycle cannot win again.
//  - At each posedge with hold=0 and eligible!=0:
//      winner = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
//      bank[wr_addr[winner]] <= wr_data[winner]; the enable is for that entry only.
//      gnt <= onehot(winner); rr_ptr <= (winner+1) mod NREQ, wrapping NREQ-1 -> 0.
//  - eligible==0 or hold=1: gnt <= 0, bank and rr_ptr unchanged.
//    hold=1 also forces busy <= 0.
//  - busy <= |(eligible & ~onehot(winner)) when hold=0.
//  - Handshake:
//      requester drives req/addr/data stable until it samples gnt=1;
//      the write has already happened on the edge that raised gnt;
//      requester may drop or re-arm req after that.
//  - Latency: data is in the bank, and readable on rd_data, 1 edge after a winning req.
//    gnt is visible in the same cycle.
//  - Throughput: 1 write per cycle total.
//    The same requester wins at most every other cycle (gnt masking).
//  - Out-of-range wr_addr (>= DEPTH when DEPTH < 2**ADDR_W): the write is dropped.
//    gnt is still issued.
//  - Two requesters targeting the same address: only the winner writes.
//    The loser writes on a later grant, so last-granted wins.
//  - Read-during-write of the same entry: rd_data shows the old value until the edge.
//    There is no bypass.
//  - Reset mid-request: everything clears; pending requests re-arbitrate from rr_ptr=0
//    after rst falls.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//    - If the winner has lock[winner]=1, rr_ptr <= winner instead of winner+1.
//    - The locked requester keeps top priority: it wins every other cycle while req is held.
//    - When lock drops, normal advance resumes on its next win.
//  ARB_LOCK_EN undefined:
//    - The lock port is present but ignored.
//    - Pure round-robin.
// TESTING
//  1 Reset:
//    rst=1 with req=4'b1111 -> gnt=0, busy=0, rd_data=0 for every rd_addr.
//  2 Single requester:
//    req=4'b0010, addr1=5, data1=8'hA5 -> next cycle gnt=4'b0010, bank[5]=8'hA5;
//    the following cycle gnt=0 (masked).
//  3 Round-robin order:
//    req=4'b1111 held, distinct addrs 0..3 -> gnt sequence 0001,0010,0100,1000,0001;
//    busy=1 throughout.
//  4 Hold:
//    hold=1 with req=4'b0101 for 3 cycles -> gnt=0 and the bank is unchanged.
//    hold=0 -> grant goes to requester 0 if rr_ptr=0.
//  5 Same-address conflict:
//    req0 and req2 both target addr 7 (data 11, 22), rr_ptr=0
//    -> bank[7]=11, then bank[7]=22; gnt 0001 then 0100.
//  6 ARB_LOCK_EN:
//    lock0=1, req=4'b0011 held -> gnt 0001,0010,0001,0010.
//    Without the macro the order is the same, but rr_ptr advances.
//    Check rr_ptr=1 vs 0 after the first grant.

Source files
------------

// File: rtl/rr_reg_bank_arbiter_if.sv
// Write/read bus shared between the requesters, consumers and the rr_reg_bank_arbiter bank.
// Requesters drive the master side; the arbiter implements the slave side.
interface rr_reg_bank_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 3,
   parameter int WIDTH  = 8
);
   logic                     hold;
   logic [NREQ-1:0]          req;
   logic [NREQ*ADDR_W-1:0]   wr_addr;
   logic [NREQ*WIDTH-1:0]    wr_data;
   logic [NREQ-1:0]          lock;
   logic [NREQ-1:0]          gnt;
   logic                     busy;
   logic [ADDR_W-1:0]        rd_addr;
   logic [WIDTH-1:0]         rd_data;

   modport master (
      output hold, req, wr_addr, wr_data, lock, rd_addr,
      input  gnt, busy, rd_data
   );

   modport slave (
      input  hold, req, wr_addr, wr_data, lock, rd_addr,
      output gnt, busy, rd_data
   );
endinterface

// File: rtl/rr_reg_bank_arbiter.sv
// Round-robin arbitrated register bank: one write per cycle among NREQ requesters, async read.
// Optional macro ARB_LOCK_EN: a locked winner keeps top priority instead of advancing rr_ptr.
module rr_reg_bank_arbiter #(
   parameter int NREQ   = 4,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int WIDTH  = 8
) (
   input logic                   clk,
   input logic                   rst,
   rr_reg_bank_arbiter_if.slave  bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [WIDTH-1:0]  bank_q [DEPTH];
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   winner_oh;
   logic [PTR_W-1:0]  winner;
   logic              found;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_sel_addr;
   logic [WIDTH-1:0]  wr_sel_data;

   // Scan from rr_ptr upward with wraparound; the first eligible index wins.
   always_comb begin
      eligible  = bus.req & ~gnt_q;
      winner    = '0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
      winner_oh = '0;
      if (found) winner_oh[winner] = 1'b1;
   end

   always_comb begin
      wr_sel_addr = bus.wr_addr[winner*ADDR_W +: ADDR_W];
      wr_sel_data = bus.wr_data[winner*WIDTH +: WIDTH];
      wr_en_d     = found && !bus.hold &&
                    ({1'b0, wr_sel_addr} < (ADDR_W+1)'(DEPTH));
      gnt_d       = '0;
      busy_d      = 1'b0;
      rr_ptr_d    = rr_ptr_q;
      if (!bus.hold) begin
         busy_d = |(eligible & ~winner_oh);
         if (found) begin
            gnt_d = winner_oh;
            if (winner == PTR_W'(NREQ-1)) rr_ptr_d = '0;
            else                          rr_ptr_d = winner + PTR_W'(1);
`ifdef ARB_LOCK_EN
            if (bus.lock[winner]) rr_ptr_d = winner;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         rr_ptr_q <= '0;
      end else begin
         gnt_q    <= gnt_d;
         busy_q   <= busy_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Each entry only loads when the granted write targets it.
   for (genvar e = 0; e < DEPTH; e++) begin : g_bank
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            bank_q[e] <= '0;
         else if (wr_en_d && (wr_sel_addr == ADDR_W'(e)))
            bank_q[e] <= wr_sel_data;
      end
   end

   always_comb begin
      bus.gnt  = gnt_q;
      bus.busy = busy_q;
      if ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH))
         bus.rd_data = bank_q[bus.rd_addr];
      else
         bus.rd_data = '0;
   end
endmodule

// File: tb/tb_rr_reg_bank_arbiter.sv
// Directed self-checking bench for rr_reg_bank_arbiter (default and ARB_LOCK_EN builds).
module tb_rr_reg_bank_arbiter;
   localparam int NREQ   = 4;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int WIDTH  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   rr_reg_bank_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

   rr_reg_bank_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      bus.wr_addr[i*ADDR_W +: ADDR_W] = a;
      bus.wr_data[i*WIDTH +: WIDTH]   = d;
   endtask

   task automatic do_reset();
      bus.req  = '0;
      bus.hold = 1'b0;
      bus.lock = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.hold = 1'b0;
      bus.lock = '0;
      bus.rd_addr = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i), WIDTH'(8'h30 + i));
      bus.req = 4'b1111;
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      #1;
      total++;
      if (bus.gnt !== 4'b0000) begin
         bad++; $display("[TB] FAIL reset_gnt_async got=%b exp=%b", bus.gnt, 4'b0000);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_busy_async got=%b exp=0", bus.busy);
      end
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = ADDR_W'(a);
         #1;
         total++;
         if (bus.rd_data !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_bank[%0d] got=%h exp=00", a, bus.rd_data);
         end
      end
      step();
      total++;
      if (bus.gnt !== 4'b0000) begin
         bad++; $display("[TB] FAIL reset_gnt_held got=%b exp=0000", bus.gnt);
      end
      bus.req = '0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 3'd5, 8'hA5);
      bus.req = 4'b0010;
      bus.rd_addr = 3'd5;
      #1;
      total++;
      if (bus.rd_data !== 8'h00) begin
         bad++; $display("[TB] FAIL single_no_bypass got=%h exp=00", bus.rd_data);
      end
      step();
      total++;
      if (bus.gnt !== 4'b0010) begin
         bad++; $display("[TB] FAIL single_gnt got=%b exp=0010", bus.gnt);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("[TB] FAIL single_busy got=%b exp=0", bus.busy);
      end
      total++;
      if (bus.rd_data !== 8'hA5) begin
         bad++; $display("[TB] FAIL single_data got=%h exp=a5", bus.rd_data);
      end
      step();
      total++;
      if (bus.gnt !== 4'b0000) begin
         bad++; $display("[TB] FAIL single_masked got=%b exp=0000", bus.gnt);
      end
      step();
      total++;
      if (bus.gnt !== 4'b0010) begin
         bad++; $display("[TB] FAIL single_regrant got=%b exp=0010", bus.gnt);
      end
      bus.req = '0;
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp_gnt [5];
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
      exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i), WIDTH'(8'h10 + i));
      bus.req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if (bus.gnt !== exp_gnt[c]) begin
            bad++; $display("[TB] FAIL rr_gnt[%0d] got=%b exp=%b", c, bus.gnt, exp_gnt[c]);
         end
         total++;
         if (bus.busy !== 1'b1) begin
            bad++; $display("[TB] FAIL rr_busy[%0d] got=%b exp=1", c, bus.busy);
         end
      end
      bus.req = '0;
      for (int a = 0; a < NREQ; a++) begin
         bus.rd_addr = ADDR_W'(a);
         #1;
         total++;
         if (bus.rd_data !== WIDTH'(8'h10 + a)) begin
            bad++; $display("[TB] FAIL rr_bank[%0d] got=%h exp=%h", a, bus.rd_data, 8'h10 + a);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      set_req(0, 3'd6, 8'h66);
      set_req(2, 3'd4, 8'h44);
      bus.hold = 1'b1;
      bus.req  = 4'b0101;
      bus.rd_addr = 3'd6;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (bus.gnt !== 4'b0000) begin
            bad++; $display("[TB] FAIL hold_gnt[%0d] got=%b exp=0000", c, bus.gnt);
         end
         total++;
         if (bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL hold_busy[%0d] got=%b exp=0", c, bus.busy);
         end
         total++;
         if (bus.rd_data !== 8'h00) begin
            bad++; $display("[TB] FAIL hold_bank[%0d] got=%h exp=00", c, bus.rd_data);
         end
      end
      bus.hold = 1'b0;
      step();
      total++;
      if (bus.gnt !== 4'b0001) begin
         bad++; $display("[TB] FAIL hold_release_gnt got=%b exp=0001", bus.gnt);
      end
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("[TB] FAIL hold_release_busy got=%b exp=1", bus.busy);
      end
      total++;
      if (bus.rd_data !== 8'h66) begin
         bad++; $display("[TB] FAIL hold_release_data got=%h exp=66", bus.rd_data);
      end
      bus.req = '0;
   endtask

   task automatic test_conflict();
      do_reset();
      set_req(0, 3'd7, 8'd11);
      set_req(2, 3'd7, 8'd22);
      bus.req = 4'b0101;
      bus.rd_addr = 3'd7;
      step();
      total++;
      if (bus.gnt !== 4'b0001) begin
         bad++; $display("[TB] FAIL conflict_gnt0 got=%b exp=0001", bus.gnt);
      end
      total++;
      if (bus.rd_data !== 8'd11) begin
         bad++; $display("[TB] FAIL conflict_data0 got=%0d exp=11", bus.rd_data);
      end
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("[TB] FAIL conflict_busy0 got=%b exp=1", bus.busy);
      end
      step();
      total++;
      if (bus.gnt !== 4'b0100) begin
         bad++; $display("[TB] FAIL conflict_gnt1 got=%b exp=0100", bus.gnt);
      end
      total++;
      if (bus.rd_data !== 8'd22) begin
         bad++; $display("[TB] FAIL conflict_data1 got=%0d exp=22", bus.rd_data);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("[TB] FAIL conflict_busy1 got=%b exp=0", bus.busy);
      end
      bus.req = '0;
   endtask

   task automatic test_lock();
      logic [NREQ-1:0] exp_gnt [4];
      logic [1:0]      exp_ptr1;
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010;
      exp_gnt[2] = 4'b0001; exp_gnt[3] = 4'b0010;
`ifdef ARB_LOCK_EN
      exp_ptr1 = 2'd0;
`else
      exp_ptr1 = 2'd1;
`endif
      do_reset();
      set_req(0, 3'd1, 8'hC0);
      set_req(1, 3'd2, 8'hC1);
      bus.lock = 4'b0001;
      bus.req  = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         step();
         total++;
         if (bus.gnt !== exp_gnt[c]) begin
            bad++; $display("[TB] FAIL lock_gnt[%0d] got=%b exp=%b", c, bus.gnt, exp_gnt[c]);
         end
         if (c == 0) begin
            total++;
            if (dut.rr_ptr_q !== exp_ptr1) begin
               bad++; $display("[TB] FAIL lock_rr_ptr got=%0d exp=%0d", dut.rr_ptr_q, exp_ptr1);
            end
         end
      end
      bus.req  = '0;
      bus.lock = '0;
   endtask

   initial begin
      bus.hold    = 1'b0;
      bus.req     = '0;
      bus.lock    = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_hold();
      test_conflict();
      test_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
